// File: rtl/sdram_port_arbiter.sv
// Two-master round-robin arbiter in front of the SDRAM controller's Avalon-MM slave.
// Grants one single-beat command at a time and routes read data back through an owner-tag FIFO.
module sdram_port_arbiter #(
   parameter int ADDR_W      = 24,
   parameter int DATA_W      = 16,
   parameter int MAX_PENDING = 4
) (
   input  logic                  clk_clk,
   input  logic                  reset_reset_n,

   input  logic [ADDR_W-1:0]     m0_address,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic [DATA_W-1:0]     m0_writedata,
   input  logic [DATA_W/8-1:0]   m0_byteenable,
   output logic                  m0_waitrequest,
   output logic [DATA_W-1:0]     m0_readdata,
   output logic                  m0_readdatavalid,

   input  logic [ADDR_W-1:0]     m1_address,
   input  logic                  m1_read,
   input  logic                  m1_write,
   input  logic [DATA_W-1:0]     m1_writedata,
   input  logic [DATA_W/8-1:0]   m1_byteenable,
   output logic                  m1_waitrequest,
   output logic [DATA_W-1:0]     m1_readdata,
   output logic                  m1_readdatavalid,

   output logic [ADDR_W-1:0]     s_address,
   output logic                  s_read,
   output logic                  s_write,
   output logic [DATA_W-1:0]     s_writedata,
   output logic [DATA_W/8-1:0]   s_byteenable,
   input  logic                  s_waitrequest,
   input  logic [DATA_W-1:0]     s_readdata,
   input  logic                  s_readdatavalid,

   output logic                  err_orphan
);

   localparam int BE_W  = DATA_W / 8;
   localparam int PTR_W = $clog2(MAX_PENDING);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {
      IDLE,
      ISSUE
   } state_t;

   state_t              state_q, state_d;
   logic                owner_q;
   logic                last_owner_q;
   logic [ADDR_W-1:0]   cmd_addr_q;
   logic [DATA_W-1:0]   cmd_wdata_q;
   logic [BE_W-1:0]     cmd_be_q;
   logic                cmd_read_q;
   logic                cmd_write_q;
   logic                err_orphan_q;

   logic                tag_mem [MAX_PENDING];
   logic [PTR_W-1:0]    wr_ptr_q;
   logic [PTR_W-1:0]    rd_ptr_q;
   logic [CNT_W-1:0]    count_q;

   logic                fifo_full;
   logic                fifo_empty;
   logic                elig0;
   logic                elig1;
   logic                grant_valid;
   logic                grant_sel;
   logic                load_cmd;
   logic                accept;
   logic                push;
   logic                pop;
   logic                head_tag;

   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic [BE_W-1:0]     sel_be;
   logic                sel_read;
   logic                sel_write;

   // Arbitration: a read is only eligible while there is room for its return tag.
   always_comb begin
      fifo_full   = (count_q == CNT_W'(MAX_PENDING));
      fifo_empty  = (count_q == '0);
      elig0       = m0_write | (m0_read & ~fifo_full);
      elig1       = m1_write | (m1_read & ~fifo_full);
      grant_valid = elig0 | elig1;
      grant_sel   = (elig0 & elig1) ? ~last_owner_q : elig1;
      load_cmd    = (state_q == IDLE) & grant_valid;
      accept      = (state_q == ISSUE) & ~s_waitrequest;
      push        = accept & cmd_read_q;
      pop         = s_readdatavalid & ~fifo_empty;
      head_tag    = tag_mem[rd_ptr_q];
   end

   always_comb begin
      sel_addr  = m0_address;
      sel_wdata = m0_writedata;
      sel_be    = m0_byteenable;
      sel_read  = m0_read;
      sel_write = m0_write;
      if (grant_sel) begin
         sel_addr  = m1_address;
         sel_wdata = m1_writedata;
         sel_be    = m1_byteenable;
         sel_read  = m1_read;
         sel_write = m1_write;
      end
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         cmd_addr_q   <= '0;
         cmd_wdata_q  <= '0;
         cmd_be_q     <= '0;
         cmd_read_q   <= 1'b0;
         cmd_write_q  <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         err_orphan_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load_cmd) begin
            owner_q     <= grant_sel;
            cmd_addr_q  <= sel_addr;
            cmd_wdata_q <= sel_wdata;
            cmd_be_q    <= sel_be;
            cmd_read_q  <= sel_read;
            cmd_write_q <= sel_write;
         end
         if (accept) begin
            last_owner_q <= owner_q;
         end
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         // Simultaneous push and pop leaves occupancy unchanged.
         if (push && !pop) begin
            count_q <= count_q + CNT_W'(1);
         end else if (pop && !push) begin
            count_q <= count_q - CNT_W'(1);
         end
         if (s_readdatavalid && fifo_empty) begin
            err_orphan_q <= 1'b1;
         end
      end
   end

   // Tag storage needs no reset: entries are only read behind the occupancy count.
   always_ff @(posedge clk_clk) begin
      if (push) begin
         tag_mem[wr_ptr_q] <= owner_q;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (grant_valid)    state_d = ISSUE;
         ISSUE:   if (!s_waitrequest) state_d = IDLE;
         default:                     state_d = IDLE;
      endcase
   end

   always_comb begin
      s_address        = cmd_addr_q;
      s_writedata      = cmd_wdata_q;
      s_byteenable     = cmd_be_q;
      s_read           = (state_q == ISSUE) & cmd_read_q;
      s_write          = (state_q == ISSUE) & cmd_write_q;
      m0_waitrequest   = ~(accept & ~owner_q);
      m1_waitrequest   = ~(accept & owner_q);
      m0_readdatavalid = pop & ~head_tag;
      m1_readdatavalid = pop & head_tag;
      m0_readdata      = s_readdata;
      m1_readdata      = s_readdata;
      err_orphan       = err_orphan_q;
   end

   a_cmd_hold: assert property (@(posedge clk_clk) disable iff (!reset_reset_n)
      ((s_read || s_write) && s_waitrequest) |=>
         $stable({s_read, s_write, s_address, s_writedata, s_byteenable}));

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: grant order, Avalon hold, tag FIFO limits and orphan data.
module tb_sdram_port_arbiter;

   logic          clk_clk = 1'b0;
   logic          reset_reset_n;
   logic [23:0]   m0_address, m1_address, s_address;
   logic          m0_read, m0_write, m1_read, m1_write;
   logic [15:0]   m0_writedata, m1_writedata, s_writedata;
   logic [1:0]    m0_byteenable, m1_byteenable, s_byteenable;
   logic          m0_waitrequest, m1_waitrequest;
   logic [15:0]   m0_readdata, m1_readdata, s_readdata;
   logic          m0_readdatavalid, m1_readdatavalid;
   logic          s_read, s_write, s_waitrequest, s_readdatavalid;
   logic          err_orphan;

   int            tests = 0;
   int            fails = 0;
   logic [16:0]   sb_q [$];   // {owner tag, expected read data}

   sdram_port_arbiter #(.ADDR_W(24), .DATA_W(16), .MAX_PENDING(4)) dut (
      .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
      .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
      .m1_readdatavalid(m1_readdatavalid),
      .s_address(s_address), .s_read(s_read), .s_write(s_write),
      .s_writedata(s_writedata), .s_byteenable(s_byteenable),
      .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
      .s_readdatavalid(s_readdatavalid), .err_orphan(err_orphan)
   );

   always #5 clk_clk = ~clk_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_clk);
      #1;
   endtask

   task automatic apply_reset(input int cycles);
      reset_reset_n = 1'b0;
      m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
      m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
      m0_byteenable = '0; m1_byteenable = '0;
      s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b0;
      repeat (cycles) tick();
      reset_reset_n = 1'b1;
   endtask

   // Present one command and wait (bounded) for the slave to accept it.
   task automatic issue(input bit m, input bit rd, input logic [23:0] a,
                        input logic [15:0] wd, input logic [15:0] rdata);
      bit acc = 1'b0;
      if (!m) begin
         m0_address = a; m0_read = rd; m0_write = ~rd; m0_writedata = wd; m0_byteenable = 2'b11;
      end else begin
         m1_address = a; m1_read = rd; m1_write = ~rd; m1_writedata = wd; m1_byteenable = 2'b11;
      end
      for (int n = 0; n < 10 && !acc; n++) begin
         tick();
         acc = m ? !m1_waitrequest : !m0_waitrequest;
      end
      if (acc && rd) sb_q.push_back({m, rdata});
      if (!m) begin m0_read = 1'b0; m0_write = 1'b0; end
      else    begin m1_read = 1'b0; m1_write = 1'b0; end
      chk("issue_accept", 32'(acc), 1);
   endtask

   task automatic slave_return(input logic [15:0] d);
      s_readdatavalid = 1'b1;
      s_readdata      = d;
      tick();
      s_readdatavalid = 1'b0;
   endtask

   // Read-return scoreboard: every readdatavalid must match the oldest expected entry.
   always @(negedge clk_clk) begin
      if (reset_reset_n && (m0_readdatavalid || m1_readdatavalid)) begin
         if (sb_q.size() == 0) begin
            chk("rdv_unexpected", 32'({m1_readdatavalid, m0_readdatavalid}), 0);
         end else begin
            logic [16:0] e;
            e = sb_q.pop_front();
            chk("rdv_owner", 32'({m1_readdatavalid, m0_readdatavalid}), e[16] ? 2 : 1);
            chk("rdv_data", 32'(e[16] ? m1_readdata : m0_readdata), 32'(e[15:0]));
         end
      end
   end

   initial begin
      int  k0, k1, grants, exp_owner;
      bit  m1_done, acc;

      // Reset state
      apply_reset(3);
      chk("rst_m0_wait", 32'(m0_waitrequest), 1);
      chk("rst_m1_wait", 32'(m1_waitrequest), 1);
      chk("rst_s_read", 32'(s_read), 0);
      chk("rst_s_write", 32'(s_write), 0);
      chk("rst_err", 32'(err_orphan), 0);

      // Single read from m0, slave latency 3
      m0_address = 24'h000123; m0_read = 1'b1; m0_byteenable = 2'b11;
      #1;
      chk("rd_T_wait", 32'(m0_waitrequest), 1);
      chk("rd_T_sread", 32'(s_read), 0);
      tick();
      chk("rd_T1_sread", 32'(s_read), 1);
      chk("rd_T1_addr", 32'(s_address), 'h000123);
      chk("rd_T1_m0wait", 32'(m0_waitrequest), 0);
      chk("rd_T1_m1wait", 32'(m1_waitrequest), 1);
      sb_q.push_back({1'b0, 16'hBEEF});
      m0_read = 1'b0;
      tick();
      chk("rd_T2_sread", 32'(s_read), 0);
      chk("rd_T2_m0wait", 32'(m0_waitrequest), 1);
      chk("rd_T2_rdv", 32'(m0_readdatavalid), 0);
      tick();
      chk("rd_T3_rdv", 32'(m0_readdatavalid), 0);
      tick();
      s_readdatavalid = 1'b1; s_readdata = 16'hBEEF;
      #1;
      chk("rd_T4_m0rdv", 32'(m0_readdatavalid), 1);
      chk("rd_T4_data", 32'(m0_readdata), 'hBEEF);
      chk("rd_T4_m1rdv", 32'(m1_readdatavalid), 0);
      tick();
      s_readdatavalid = 1'b0;

      // Both masters write continuously: strict alternation starting with m0
      apply_reset(2);
      k0 = 0; k1 = 0; grants = 0; exp_owner = 0;
      m0_write = 1'b1; m0_address = 24'h000100; m0_writedata = 16'h1000; m0_byteenable = 2'b11;
      m1_write = 1'b1; m1_address = 24'h000200; m1_writedata = 16'h2000; m1_byteenable = 2'b11;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (!m0_waitrequest || !m1_waitrequest) begin
            chk("alt_owner", 32'(!m1_waitrequest), 32'(exp_owner));
            chk("alt_swrite", 32'(s_write), 1);
            if (!m0_waitrequest) begin
               chk("alt_wdata0", 32'(s_writedata), 'h1000 + k0);
               k0++;
               m0_writedata = 16'(32'h1000 + k0);
               m0_address   = 24'(32'h100 + k0);
            end else begin
               chk("alt_wdata1", 32'(s_writedata), 'h2000 + k1);
               k1++;
               m1_writedata = 16'(32'h2000 + k1);
               m1_address   = 24'(32'h200 + k1);
            end
            exp_owner = 1 - exp_owner;
            grants++;
         end
      end
      m0_write = 1'b0; m1_write = 1'b0;
      chk("alt_grants", 32'(grants), 8);

      // Slave stall during an m1 write: command held, m0 kept waiting
      m1_write = 1'b1; m1_address = 24'h0ABCDE; m1_writedata = 16'hA5A5; m1_byteenable = 2'b10;
      s_waitrequest = 1'b1;
      tick();
      m0_write = 1'b1; m0_address = 24'h000555; m0_writedata = 16'h5555; m0_byteenable = 2'b11;
      for (int i = 0; i < 5; i++) begin
         chk("stall_swrite", 32'(s_write), 1);
         chk("stall_addr", 32'(s_address), 'h0ABCDE);
         chk("stall_wdata", 32'(s_writedata), 'hA5A5);
         chk("stall_be", 32'(s_byteenable), 'b10);
         chk("stall_m0wait", 32'(m0_waitrequest), 1);
         chk("stall_m1wait", 32'(m1_waitrequest), 1);
         // Master drops its request mid-stall; the latched command must still complete.
         if (i == 2) begin m1_write = 1'b0; m1_writedata = 16'h0000; end
         tick();
      end
      s_waitrequest = 1'b0;
      #1;
      chk("stall_m1_accept", 32'(m1_waitrequest), 0);
      chk("stall_wdata_end", 32'(s_writedata), 'hA5A5);
      tick();
      chk("stall_idle_m0wait", 32'(m0_waitrequest), 1);
      tick();
      chk("stall_m0_accept", 32'(m0_waitrequest), 0);
      chk("stall_m0_addr", 32'(s_address), 'h000555);
      m0_write = 1'b0;
      tick();

      // Full tag FIFO: fifth read waits for a return, other master's write proceeds
      for (int k = 0; k < 4; k++) issue(1'b0, 1'b1, 24'(32'h000F00 + k), 16'h0, 16'(32'hC000 + k));
      m0_read = 1'b1; m0_address = 24'h000F04;
      m1_write = 1'b1; m1_address = 24'h000777; m1_writedata = 16'h7777; m1_byteenable = 2'b11;
      m1_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("full_m0_held", 32'(m0_waitrequest), 1);
         if (!m1_waitrequest) begin
            m1_done = 1'b1;
            m1_write = 1'b0;
            chk("full_m1_wdata", 32'(s_writedata), 'h7777);
         end
      end
      chk("full_m1_issued", 32'(m1_done), 1);
      slave_return(16'hC000);
      acc = 1'b0;
      for (int n = 0; n < 5 && !acc; n++) begin
         if (n > 0) tick();
         acc = !m0_waitrequest;
      end
      chk("full_m0_released", 32'(acc), 1);
      if (acc) sb_q.push_back({1'b0, 16'hC004});
      m0_read = 1'b0;
      tick();
      for (int k = 1; k < 5; k++) slave_return(16'(32'hC000 + k));
      tick();
      chk("full_sb_drained", 32'(sb_q.size()), 0);

      // Reset with a read outstanding: late data is an orphan
      issue(1'b1, 1'b1, 24'h000321, 16'h0, 16'h0);
      void'(sb_q.pop_back());
      apply_reset(2);
      s_readdatavalid = 1'b1; s_readdata = 16'hDEAD;
      #1;
      chk("late_m0rdv", 32'(m0_readdatavalid), 0);
      chk("late_m1rdv", 32'(m1_readdatavalid), 0);
      tick();
      s_readdatavalid = 1'b0;
      chk("late_err", 32'(err_orphan), 1);

      // Plain orphan on an empty FIFO, sticky until reset
      apply_reset(2);
      chk("orph_err_clr", 32'(err_orphan), 0);
      s_readdatavalid = 1'b1; s_readdata = 16'h1234;
      #1;
      chk("orph_m0rdv", 32'(m0_readdatavalid), 0);
      chk("orph_m1rdv", 32'(m1_readdatavalid), 0);
      tick();
      s_readdatavalid = 1'b0;
      chk("orph_err_set", 32'(err_orphan), 1);
      repeat (3) tick();
      chk("orph_err_sticky", 32'(err_orphan), 1);
      apply_reset(1);
      tick();
      chk("orph_err_reset", 32'(err_orphan), 0);
      chk("final_sb_empty", 32'(sb_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
